fifo_rd_port: RTL

Read-side controller of the asynchronous FIFO in the SDRAM controller's clock-crossing paths. It drives the read address of the FIFO dual-port memory, which returns data combinationally. It synchronises the Gray-coded write pointer from the far domain and computes empty and fill level. It presents words on a first-word-fall-through valid/ready output register, and returns its own Gray read pointer to the write side for full detection.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_sync.sv | 24 ++
 rtl/fifo_rd_port.sv | 72 +++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers.
package fifo_pkg;

    localparam int SyncStages = 2;

    // Width-generic Gray/binary conversion, shared by both FIFO sides.
    virtual class gray_conv #(parameter int W = 4);
        static function logic [W-1:0] bin2gray(input logic [W-1:0] b);
            return b ^ (b >> 1);
        endfunction

        static function logic [W-1:0] gray2bin(input logic [W-1:0] g);
            logic [W-1:0] b;
            b[W-1] = g[W-1];
            for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
            return b;
        endfunction
    endclass

endpackage

// File: rtl/fifo_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this domain.
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int Width  = 4,
    parameter int Stages = SyncStages
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Stages-1:0][Width-1:0] sync_q;

    // Shift the far-domain pointer through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '0;
        else          sync_q <= {sync_q[Stages-2:0], i_d};
    end

    assign o_q = sync_q[Stages-1];

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side controller of the async FIFO: pointer, empty, level and a
// first-word-fall-through output register in front of the consumer.
module fifo_rd_port
    import fifo_pkg::*;
#(
    parameter  int DataWidth = 8,
    parameter  int Depth     = 8,
    localparam int AddrWidth = $clog2(Depth),
    localparam int PW        = AddrWidth + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [PW-1:0]        i_wr_ptr_gray,
    output logic [PW-1:0]        o_rd_ptr_gray,
    output logic [AddrWidth-1:0] o_rd_addr,
    input  logic [DataWidth-1:0] i_rd_data,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_empty,
    output logic [PW-1:0]        o_mem_level
);

    logic [PW-1:0] wq2;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_gray;
    logic [PW-1:0] rd_bin_nxt;
    logic          fetch;

    fifo_sync #(
        .Width  (PW),
        .Stages (SyncStages)
    ) u_wr_ptr_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_wr_ptr_gray),
        .o_q     (wq2)
    );

    assign rd_bin_nxt    = rd_bin + PW'(1);
    assign o_empty       = (rd_gray == wq2);
    assign o_mem_level   = gray_conv#(PW)::gray2bin(wq2) - rd_bin;
    // Refill the output register when it is free or being drained this cycle.
    assign fetch         = !o_empty && (!o_valid || i_ready);
    assign o_rd_addr     = rd_bin[AddrWidth-1:0];
    assign o_rd_ptr_gray = rd_gray;

    // Advance the read pointer (binary and Gray copies) on each fetch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_bin  <= '0;
            rd_gray <= '0;
        end else if (fetch) begin
            rd_bin  <= rd_bin_nxt;
            rd_gray <= gray_conv#(PW)::bin2gray(rd_bin_nxt);
        end
    end

    // Output register: load on fetch, drop valid on a plain accept, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (fetch) begin
            o_data  <= i_rd_data;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
